// File: rtl/parallel_send.sv
// ---------------------------------------------------------------------------
// parallel_send
// Transmit-side pattern generator for the 32-bit parallel link test path.
// Each frame has GAP_LEN filler words, then one INIT strobe, then BURST_LEN
// data words. Every filler carries the inverted pattern counter and then
// advances it. Every burst word carries the current pattern value unchanged.
// The far-end checker tracks the same counter. It can therefore validate
// every burst word against its own reference.
//
// Parameters
//   BURST_LEN  data words per burst (1..65535)
//   GAP_LEN    filler words before each INIT (1..65535)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active-high (priority over CLR)
//   CLR        in   synchronous clear, same effect as RST
//   EN         in   run enable (level)
//   DOREADY    in   pacing strobe; each high sample permits one word
//   ERR_INJ    in   pulse: corrupt DOUT[0] of the next burst word
//   INIT       out  one-cycle frame-start strobe (registered)
//   DOPUSH     out  word-valid strobe (registered)
//   DOUT       out  word data (registered), valid when DOPUSH=1
//   BUSY       out  high whenever the FSM is not idle
//   BURST_CNT  out  completed bursts, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module parallel_send #(
    parameter int BURST_LEN = 1024,
    parameter int GAP_LEN   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    input  logic        EN,
    input  logic        DOREADY,
    input  logic        ERR_INJ,
    output logic        INIT,
    output logic        DOPUSH,
    output logic [31:0] DOUT,
    output logic        BUSY,
    output logic [15:0] BURST_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        INITS = 2'd2,
        BURST = 2'd3
    } state_t;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);
    localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

    state_t      state_q, state_d;
    logic [31:0] pattern_q, pattern_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        inj_q, inj_d;
    logic        init_q, init_d;
    logic        push_q, push_d;
    logic [31:0] dout_q, dout_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic        inj_pend;

    // A pulse that arrives in the same cycle as a burst word already
    // applies to that word. Repeated pulses collapse into one pending flag.
    assign inj_pend = inj_q | ERR_INJ;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        gap_cnt_d   = gap_cnt_q;
        word_cnt_d  = word_cnt_q;
        inj_d       = inj_pend;
        init_d      = 1'b0;
        push_d      = 1'b0;
        dout_d      = dout_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d   = GAP;
                    gap_cnt_d = 16'd0;
                end
            end
            GAP: begin
                if (DOREADY) begin
                    push_d    = 1'b1;
                    dout_d    = ~pattern_q;
                    pattern_d = pattern_q + 32'd1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = INITS;
                        gap_cnt_d = 16'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
            end
            INITS: begin
                // DOREADY is ignored here on purpose: the pacing slot is lost.
                init_d     = 1'b1;
                state_d    = BURST;
                word_cnt_d = 16'd0;
            end
            BURST: begin
                if (DOREADY) begin
                    push_d = 1'b1;
                    dout_d = pattern_q ^ {31'd0, inj_pend};
                    inj_d  = 1'b0;
                    if (word_cnt_q == BURST_LAST) begin
                        word_cnt_d = 16'd0;
                        gap_cnt_d  = 16'd0;
                        if (burst_cnt_q != 16'hFFFF) begin
                            burst_cnt_d = burst_cnt_q + 16'd1;
                        end
                        // EN is only sampled at frame boundaries.
                        state_d = EN ? GAP : IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_q     <= IDLE;
            pattern_q   <= 32'd0;
            gap_cnt_q   <= 16'd0;
            word_cnt_q  <= 16'd0;
            inj_q       <= 1'b0;
            init_q      <= 1'b0;
            push_q      <= 1'b0;
            dout_q      <= 32'd0;
            burst_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            gap_cnt_q   <= gap_cnt_d;
            word_cnt_q  <= word_cnt_d;
            inj_q       <= inj_d;
            init_q      <= init_d;
            push_q      <= push_d;
            dout_q      <= dout_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign INIT      = init_q;
    assign DOPUSH    = push_q;
    assign DOUT      = dout_q;
    assign BUSY      = (state_q != IDLE);
    assign BURST_CNT = burst_cnt_q;

endmodule
